// File: rtl/pxie_pkg.sv
// Shared definitions for the PXIE card-to-host readback path:
// FSM state encoding, header constants and the header word builder.
package pxie_pkg;

    localparam logic [15:0] C2H_SYNC = 16'heb9c;
    localparam logic [15:0] C2H_TYPE = 16'h2000;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_HDR_ENC   = 3'd1;
    localparam logic [2:0] ST_READ_ENC  = 3'd2;
    localparam logic [2:0] ST_DRAIN_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_HDR   = ST_HDR_ENC,
        ST_READ  = ST_READ_ENC,
        ST_DRAIN = ST_DRAIN_ENC,
        ST_DONE  = ST_DONE_ENC
    } c2h_state_e;

    // Header word placed ahead of RAM data when the header build option is on.
    function automatic logic [127:0] c2h_hdr_word(input logic [15:0] len,
                                                  input logic [15:0] addr);
        return {64'h0, C2H_SYNC, C2H_TYPE, len, addr};
    endfunction

endpackage

// File: rtl/pxie_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// Head data reads as zero while empty so the stream bus is quiet when idle.
module pxie_sync_fifo #(
    parameter int DW       = 128,
    parameter int FIFO_DEP = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  logic [DW-1:0]               wdata_i,
    input  logic                        pop_i,
    output logic [DW-1:0]               rdata_o,
    output logic [$clog2(FIFO_DEP):0]   count_o,
    output logic                        full_o,
    output logic                        empty_o
);
    localparam int PW = $clog2(FIFO_DEP);

    logic [DW-1:0] mem_q [FIFO_DEP];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   cnt_q;
    logic          wr_en;
    logic          rd_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(FIFO_DEP));
    assign count_o = cnt_q;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array; data is not reset, only the pointers are.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/pxie_c2h_read_ctrl.sv
// Card-to-host readback sequencer: reads a block of words from the shared
// RAM through a fixed-latency read port and streams them out through a FIFO.
// Optional build macro: C2H_HEADER_EN (prepend one header word per transfer).
module pxie_c2h_read_ctrl
    import pxie_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 128,
    parameter int RD_LAT   = 2,
    parameter int FIFO_DEP = 8
) (
    input  logic          I_PXIE_CLK,
    input  logic          I_Rst_n,
    input  logic          I_C2H_En,
    input  logic [AW-1:0] I_C2H_Addr,
    input  logic [15:0]   I_C2H_Len,
    output logic          O_Ram_Rden,
    output logic [AW-1:0] O_Ram_Raddr,
    input  logic [DW-1:0] I_Ram_Rdata,
    output logic [DW-1:0] O_C2H_Data,
    output logic          O_C2H_Vld,
    input  logic          I_C2H_Rdy,
    output logic          O_Busy,
    output logic          O_Done
);
    localparam int CW = $clog2(FIFO_DEP) + 1;

    c2h_state_e        state_q;
    logic [AW-1:0]     addr_q;
    logic [15:0]       rem_q;
    logic              busy_q;
    logic              done_q;
    logic [CW-1:0]     infl_q;
    logic [RD_LAT-1:0] vld_sr_q;

    logic [CW-1:0]     fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DW-1:0]     fifo_rdata;
    logic [DW-1:0]     fifo_wdata;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CW:0]       credit_used;
    logic              credit_ok;
    logic              rd_issue;
    logic              ram_push;
    logic              hdr_push;
    logic              last_pop;

    // Reads already issued plus words buffered must never exceed the FIFO depth,
    // so every returning word is guaranteed a slot.
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, infl_q};
    assign credit_ok   = !fifo_full && (credit_used < (CW+1)'(FIFO_DEP));
    assign rd_issue    = (state_q == ST_READ) && credit_ok;
    assign ram_push    = vld_sr_q[RD_LAT-1];
    assign fifo_pop    = !fifo_empty && I_C2H_Rdy;
    // True in the cycle the final buffered word leaves with nothing still in flight.
    assign last_pop    = (infl_q == '0) &&
                         (fifo_empty || ((fifo_cnt == CW'(1)) && fifo_pop));

`ifdef C2H_HEADER_EN
    logic [DW-1:0] hdr_word;
    assign hdr_word   = DW'(c2h_hdr_word(rem_q, 16'(addr_q)));
    assign hdr_push   = (state_q == ST_HDR) && credit_ok;
    assign fifo_wdata = hdr_push ? hdr_word : I_Ram_Rdata;
`else
    assign hdr_push   = 1'b0;
    assign fifo_wdata = I_Ram_Rdata;
`endif
    assign fifo_push  = ram_push || hdr_push;

    assign O_Ram_Rden  = rd_issue;
    assign O_Ram_Raddr = addr_q;
    assign O_C2H_Data  = fifo_rdata;
    assign O_C2H_Vld   = !fifo_empty;
    assign O_Busy      = busy_q;
    assign O_Done      = done_q;

    // Return-path valid shift register: marks the cycle read data arrives.
    if (RD_LAT == 1) begin : g_sr1
        always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
            if (!I_Rst_n) vld_sr_q <= '0;
            else          vld_sr_q <= rd_issue;
        end
    end else begin : g_srn
        always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
            if (!I_Rst_n) vld_sr_q <= '0;
            else          vld_sr_q <= {vld_sr_q[RD_LAT-2:0], rd_issue};
        end
    end

    // In-flight read count: up on issue, down when the data lands in the FIFO.
    always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            infl_q <= '0;
        end else begin
            case ({rd_issue, ram_push})
                2'b10:   infl_q <= infl_q + CW'(1);
                2'b01:   infl_q <= infl_q - CW'(1);
                default: infl_q <= infl_q;
            endcase
        end
    end

    // Transfer sequencer with registered busy/done outputs.
    always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (I_C2H_En) begin
                        addr_q <= I_C2H_Addr;
                        rem_q  <= I_C2H_Len;
                        busy_q <= 1'b1;
`ifdef C2H_HEADER_EN
                        state_q <= ST_HDR;
`else
                        state_q <= (I_C2H_Len == 16'd0) ? ST_DONE : ST_READ;
`endif
                    end
                end
`ifdef C2H_HEADER_EN
                ST_HDR: begin
                    if (hdr_push) begin
                        state_q <= (rem_q == 16'd0) ? ST_DRAIN : ST_READ;
                    end
                end
`endif
                ST_READ: begin
                    if (rd_issue) begin
                        addr_q <= addr_q + AW'(1);
                        rem_q  <= rem_q - 16'd1;
                        if (rem_q == 16'd1) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Raise done right behind the final transfer.
                    if (last_pop) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Arriving from DRAIN the pulse is already up and is closed here;
                    // arriving straight from IDLE (empty transfer) the pulse starts here.
                    busy_q  <= 1'b0;
                    done_q  <= !done_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pxie_sync_fifo #(
        .DW       (DW),
        .FIFO_DEP (FIFO_DEP)
    ) u_fifo (
        .clk_i   (I_PXIE_CLK),
        .rst_ni  (I_Rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_pxie_c2h_read_ctrl.sv
// Directed testbench for pxie_c2h_read_ctrl (default build, no header).
module tb_pxie_c2h_read_ctrl;
    localparam int AW       = 16;
    localparam int DW       = 128;
    localparam int RD_LAT   = 2;
    localparam int FIFO_DEP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [15:0]   len = '0;
    logic          ram_rden;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] c2h_data;
    logic          c2h_vld;
    logic          c2h_rdy = 1'b1;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int en_cyc = 0;
    int first_vld_cyc = -1;
    int last_xf_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int max_out = 0;
    logic [AW-1:0] rd_q [$];
    logic [DW-1:0] xf_q [$];

    pxie_c2h_read_ctrl #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIFO_DEP(FIFO_DEP)
    ) dut (
        .I_PXIE_CLK  (clk),
        .I_Rst_n     (rst_n),
        .I_C2H_En    (en),
        .I_C2H_Addr  (addr),
        .I_C2H_Len   (len),
        .O_Ram_Rden  (ram_rden),
        .O_Ram_Raddr (ram_raddr),
        .I_Ram_Rdata (ram_rdata),
        .O_C2H_Data  (c2h_data),
        .O_C2H_Vld   (c2h_vld),
        .I_C2H_Rdy   (c2h_rdy),
        .O_Busy      (busy),
        .O_Done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {16'hA5A5, a, 16'h5A5A, ~a, 64'h0123_4567_89AB_CDEF};
    endfunction

    // RAM model: data for an address strobed in cycle c is presented in cycle c+RD_LAT.
    logic [DW-1:0] ram_pipe [RD_LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= ram_rden ? ram_word(ram_raddr) : '0;
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_rdata = ram_pipe[RD_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the DUT mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rden) rd_q.push_back(ram_raddr);
            if (c2h_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (c2h_vld && c2h_rdy) begin
                xf_q.push_back(c2h_data);
                last_xf_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rd_q.size() - xf_q.size() > max_out) max_out = rd_q.size() - xf_q.size();
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        rd_q.delete();
        xf_q.delete();
        first_vld_cyc = -1;
        max_out = 0;
    endtask

    task automatic start(input logic [AW-1:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        en = 1'b1; addr = a; len = l; en_cyc = cyc;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < lim) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 128'(done_cnt), 128'(n0 + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] exp3 [4];
        int d0;
        int k;
        exp3 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_vld",   128'(c2h_vld),   128'(0));
        check("rst_busy",  128'(busy),      128'(0));
        check("rst_done",  128'(done),      128'(0));
        check("rst_rden",  128'(ram_rden),  128'(0));
        check("rst_raddr", 128'(ram_raddr), 128'(0));
        check("rst_data",  128'(c2h_data),  128'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1) four words from 0x0010, ready held high
        clear_obs();
        c2h_rdy = 1'b1;
        start(16'h0010, 16'd4);
        check("t1_busy", 128'(busy), 128'(1));
        wait_done("t1_done_seen", 100);
        check("t1_nrd", 128'(rd_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            check($sformatf("t1_addr%0d", i), 128'(rd_q[i]), 128'(16'h0010 + i));
        check("t1_nxf", 128'(xf_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < xf_q.size(); i++)
            check($sformatf("t1_data%0d", i), xf_q[i], ram_word(16'(16'h0010 + i)));
        check("t1_latency",  128'(first_vld_cyc - en_cyc), 128'(RD_LAT + 2));
        check("t1_done_gap", 128'(done_cyc - last_xf_cyc), 128'(1));
        check("t1_done_pulse", 128'(done), 128'(0));
        check("t1_busy_off",   128'(busy), 128'(0));

        // 2) zero-length transfer
        clear_obs();
        start(16'h0055, 16'd0);
        wait_done("t2_done_seen", 20);
        check("t2_nrd", 128'(rd_q.size()), 128'(0));
        check("t2_nxf", 128'(xf_q.size()), 128'(0));
        check("t2_done_lat", 128'(done_cyc - en_cyc), 128'(2));

        // 3) address wrap
        clear_obs();
        start(16'hFFFE, 16'd4);
        wait_done("t3_done_seen", 100);
        check("t3_nrd", 128'(rd_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            check($sformatf("t3_addr%0d", i), 128'(rd_q[i]), 128'(exp3[i]));
        if (xf_q.size() > 2) check("t3_data2", xf_q[2], ram_word(16'h0000));
        else                 check("t3_nxf", 128'(xf_q.size()), 128'(4));

        // 4) long backpressure then release
        clear_obs();
        c2h_rdy = 1'b0;
        start(16'h1000, 16'd32);
        repeat (40) @(posedge clk);
        #1;
        check("t4_stall_rd", 128'(rd_q.size()), 128'(FIFO_DEP));
        check("t4_stall_xf", 128'(xf_q.size()), 128'(0));
        check("t4_stall_busy", 128'(busy), 128'(1));
        c2h_rdy = 1'b1;
        wait_done("t4_done_seen", 400);
        check("t4_nxf", 128'(xf_q.size()), 128'(32));
        for (int i = 0; i < 32 && i < xf_q.size(); i++)
            check($sformatf("t4_data%0d", i), xf_q[i], ram_word(16'(16'h1000 + i)));
        check("t4_max_out", 128'(max_out), 128'(FIFO_DEP));

        // 5) second start while busy is ignored
        clear_obs();
        d0 = done_cnt;
        start(16'h0100, 16'd10);
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1; addr = 16'h0200; len = 16'd5;
        @(posedge clk); #1;
        en = 1'b0;
        wait_done("t5_done_seen", 200);
        repeat (10) @(posedge clk);
        #1;
        check("t5_done_cnt", 128'(done_cnt), 128'(d0 + 1));
        check("t5_nxf", 128'(xf_q.size()), 128'(10));
        check("t5_nrd", 128'(rd_q.size()), 128'(10));
        if (rd_q.size() == 10) begin
            check("t5_first_addr", 128'(rd_q[0]), 128'(16'h0100));
            check("t5_last_addr",  128'(rd_q[9]), 128'(16'h0109));
        end

        // 6) reset in the middle of a transfer, then a fresh transfer
        clear_obs();
        d0 = done_cnt;
        start(16'h0300, 16'd10);
        k = 0;
        while (xf_q.size() < 3 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_pre_xf", 128'(xf_q.size() >= 3), 128'(1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld",  128'(c2h_vld),  128'(0));
        check("t6_rst_busy", 128'(busy),     128'(0));
        check("t6_rst_done", 128'(done),     128'(0));
        check("t6_rst_rden", 128'(ram_rden), 128'(0));
        check("t6_rst_data", 128'(c2h_data), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_done", 128'(done_cnt), 128'(d0));
        check("t6_idle_vld", 128'(c2h_vld), 128'(0));
        clear_obs();
        start(16'h0040, 16'd2);
        wait_done("t6_done_seen", 100);
        check("t6_nxf", 128'(xf_q.size()), 128'(2));
        for (int i = 0; i < 2 && i < xf_q.size(); i++)
            check($sformatf("t6_data%0d", i), xf_q[i], ram_word(16'(16'h0040 + i)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
